dmem_lsu_ctrl: RTL and testbench
================================

Name: dmem_lsu_ctrl

Overview:
- Load/store sequencer between the single-cycle core's memory stage and the word-addressed data memory (byte enables, combinational read, write on posedge clk).
- Converts byte addresses plus funct3 into word address, byte enables, lane-shifted write data and extracted/extended load data.
- Splits misaligned accesses that straddle two words into two memory cycles, stalling the core for one extra cycle.
- Rejects out-of-range addresses and illegal funct3 encodings with a fault flag.

Parameters:
- ADDR_WIDTH, 15: word-address width of the data memory (2^15 words = 128KB).
- BASE_ADDR, 32'h0000_0000: byte address of memory word 0; must be 4-byte aligned.
- CNT_WIDTH, 16: width of the saturating misaligned-access counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  core presents a load/store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  core must hold its request stable and not advance.
- rdata  out  32  extracted and extended load result.
- fault  out  1  access rejected; no memory write occurs.
- misalign_cnt  out  CNT_WIDTH  count of split accesses, saturating.
- mem_addr  out  ADDR_WIDTH  word address to memory.
- mem_we  out  1  memory write enable.
- mem_be  out  4  memory byte enables.
- mem_op_read  out  3  tied to 3'b010; extraction is done here.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  raw word from memory.

Behaviour:
- Address decode:
  - off = addr[1:0].
  - widx = (addr - BASE_ADDR) >> 2.
  - In range iff 0 <= addr - BASE_ADDR < 4·2^ADDR_WIDTH.
  - The second word of a split is (widx+1) mod 2^ADDR_WIDTH, so the top word wraps to word 0.
- fault is combinational: req_valid & (out of range | funct3 ∈ {011,110,111} | store with funct3[2]=1).
  - On fault: mem_we=0, stall=0, rdata=0.
  - No state change and no counter increment.
- Split condition:
  - Half access with off==3.
  - Word access with off!=0.
  - Byte accesses and halfwords at off 0..2 are single-cycle.
- Mask m: byte 4'b0001, half 4'b0011, word 4'b1111.
  - be8 = {4'b0,m} << off; lane64 = {32'b0,wdata} << 8·off.
  - First access: be = be8[3:0], wdata = lane64[31:0].
  - Second access: be = be8[7:4], wdata = lane64[63:32].
- Load: raw64 = {word_hi, word_lo} >> 8·off, then sign- or zero-extend per funct3.
  - Single-cycle load: word_hi = 0, word_lo = mem_rdata.
- State machine FSM {IDLE, SECOND}:
  - IDLE, non-faulting, non-split request: access widx and complete combinationally; stall=0; stay IDLE.
  - IDLE, split request: access widx with the lower be/wdata and commit that write; capture lo_q <= mem_rdata; stall=1; go to SECOND; misalign_cnt += 1 (saturates at all-ones).
  - SECOND: access widx+1 with the upper be/wdata; rdata merges {mem_rdata, lo_q}; stall=0; go to IDLE.
  - req_valid=0 in IDLE: mem_we=0, mem_be=0, stall=0, rdata=0.
- The core must hold the request unchanged while stall=1. If req_valid drops in SECOND, the FSM still returns to IDLE and the second write is suppressed.
- Latency:
  - Aligned access: 0 extra cycles.
  - Split access: 1 extra cycle.
  - A store's written data is visible to a load in the following cycle.
- Reset (asynchronous, any time): FSM=IDLE, lo_q=0, misalign_cnt=0.
  - Outputs while rst=1: stall=0, fault=0, rdata=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Reset during SECOND abandons the upper half of a split store; the lower half stays written. This partial store is documented, not corrected.

Decomposition:
- Package dmem_lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding.
  - Mask table.
- One combinational sub-module dmem_lsu_align: lane shift and be generation for stores, plus extract/extend for loads.
- The FSM, address decode, counter and lo_q stay in dmem_lsu_ctrl.

Test Plan:
- Preload: BASE=0, mem[0]=0x44332211, mem[1]=0x88776655.
- lw @0x2 -> stall=1 for one cycle; next cycle rdata=0x66554433, stall=0; misalign_cnt=1.
- lhu @0x1 -> no stall, rdata=0x00003322. lh @0x3 -> split, rdata=0x00005544. lb @0x7 -> rdata=0xFFFFFF88.
- sw 0xDEADBEEF @0x1 -> cycle0: addr 0, be=1110, wdata=0xADBEEF00; cycle1: addr 1, be=0001, wdata=0x000000DE. Readback: mem[0]=0xADBEEF11, mem[1]=0x887766DE.
- Wrap: lw @ byte 0x1FFFE (last word, off 2), mem[last]=0xAABBCCDD -> second access mem_addr=0, rdata=0x2211AABB.
- Fault cases, each -> fault=1, mem_we=0, stall=0, misalign_cnt unchanged:
  - sw @0x20000 (out of range).
  - funct3=011.
- Assert rst during SECOND of sw 0xDEADBEEF @0x1 -> FSM immediately IDLE, all outputs 0. mem[0] lower half written, mem[1] unchanged at 0x88776655, misalign_cnt=0.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store sequencer.
// funct3 encodings, FSM state encoding and the access-size mask table.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } lsu_state_e;

    // Unshifted byte-enable mask for an access size (funct3[1:0]).
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane alignment: store byte enables and write-data shift for either half of a
// split, plus load extraction and sign/zero extension from a two-word window.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        upper,
    input  logic [31:0] wdata,
    input  logic [31:0] word_lo,
    input  logic [31:0] word_hi,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  be8;
    logic [63:0] lane64;
    logic [31:0] raw;

    always_comb begin
        be8        = {4'b0000, size_mask(funct3[1:0])} << off;
        lane64     = {32'h0000_0000, wdata} << {off, 3'b000};
        raw        = 32'({word_hi, word_lo} >> {off, 3'b000});
        be         = upper ? be8[7:4] : be8[3:0];
        lane_wdata = upper ? lane64[63:32] : lane64[31:0];
        case (funct3)
            F3_B:    load_data = {{24{raw[7]}}, raw[7:0]};
            F3_H:    load_data = {{16{raw[15]}}, raw[15:0]};
            F3_W:    load_data = raw;
            F3_BU:   load_data = {24'h000000, raw[7:0]};
            F3_HU:   load_data = {16'h0000, raw[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the core memory stage and word-addressed data
// memory; splits word-straddling accesses into two cycles and flags faults.
module dmem_lsu_ctrl
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  fault,
    output logic [CNT_WIDTH-1:0]  misalign_cnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [2:0]            mem_op_read,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned RANGE_SHIFT = ADDR_WIDTH + 2;

    lsu_state_e            state, state_nx;
    logic [31:0]           lo_q;
    logic                  cap_lo;
    logic [31:0]           rel;
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] widx;
    logic                  in_range, illegal, split, access_ok, upper;
    logic [31:0]           word_lo, word_hi;
    logic [3:0]            al_be;
    logic [31:0]           al_wdata, al_load;

    // Address decode and request legality.
    assign rel       = req_addr - BASE_ADDR;
    assign off       = rel[1:0];
    assign widx      = ADDR_WIDTH'(rel >> 2);
    assign in_range  = (rel >> RANGE_SHIFT) == 32'h0000_0000;
    assign illegal   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    assign split     = ((req_funct3[1:0] == 2'b01) && (off == 2'b11)) ||
                       ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
    assign access_ok = req_valid && in_range && !illegal;
    assign fault     = !rst && req_valid && !(in_range && !illegal);

    assign mem_op_read = 3'b010;

    assign upper   = (state == ST_SECOND);
    assign word_lo = upper ? lo_q : mem_rdata;
    assign word_hi = upper ? mem_rdata : 32'h0000_0000;

    dmem_lsu_align u_align (
        .funct3     (req_funct3),
        .off        (off),
        .upper      (upper),
        .wdata      (req_wdata),
        .word_lo    (word_lo),
        .word_hi    (word_hi),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .load_data  (al_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            lo_q         <= 32'h0000_0000;
            misalign_cnt <= '0;
        end else begin
            state <= state_nx;
            if (cap_lo) begin
                lo_q <= mem_rdata;
                if (misalign_cnt != '1) begin
                    misalign_cnt <= misalign_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        rdata     = 32'h0000_0000;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0000_0000;
        cap_lo    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access_ok) begin
                    mem_addr  = widx;
                    mem_be    = al_be;
                    mem_wdata = al_wdata;
                    mem_we    = req_we;
                    if (split) begin
                        stall    = 1'b1;
                        cap_lo   = 1'b1;
                        state_nx = ST_SECOND;
                    end else if (!req_we) begin
                        rdata = al_load;
                    end
                end
            end
            ST_SECOND: begin
                // A dropped request here abandons the upper half.
                state_nx = ST_IDLE;
                if (access_ok) begin
                    mem_addr  = widx + ADDR_WIDTH'(1);
                    mem_be    = al_be;
                    mem_wdata = al_wdata;
                    mem_we    = req_we;
                    if (!req_we) begin
                        rdata = al_load;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (rst) begin
            state_nx  = ST_IDLE;
            stall     = 1'b0;
            rdata     = 32'h0000_0000;
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_be    = 4'b0000;
            mem_wdata = 32'h0000_0000;
            cap_lo    = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed plan steps, then random
// traffic checked against a byte-array reference memory.
module tb_dmem_lsu_ctrl;

    localparam int unsigned AW     = 15;
    localparam int unsigned NWORDS = 1 << AW;
    localparam int unsigned NBYTES = NWORDS * 4;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic          clk, rst;
    logic          req_valid, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          stall, fault, mem_we;
    logic [31:0]   rdata, mem_wdata, mem_rdata;
    logic [15:0]   misalign_cnt;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [2:0]    mem_op_read;

    dmem_lsu_ctrl #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .fault(fault), .misalign_cnt(misalign_cnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_op_read(mem_op_read), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory environment: combinational read, byte-enabled write.
    logic [31:0]   mem [NWORDS];
    logic          init_mem, bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;

    function automatic logic [31:0] pat(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= pat(i);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: flat byte memory indexed by offset from BASE.
    logic [7:0] rb [NBYTES];
    int n_cmp, n_err, cnt_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        logic [31:0] r;
        r = a - BASE;
        v = 32'h0;
        for (int i = 0; i < nbytes(f3); i++) v[8*i +: 8] = rb[17'(r + 32'(i))];
        if (f3 == 3'b000) return {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) return {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r;
        r = a - BASE;
        for (int i = 0; i < nbytes(f3); i++) rb[17'(r + 32'(i))] = wd[8*i +: 8];
    endtask

    function automatic logic ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] r;
        r = a - BASE;
        return (r >= NBYTES) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

    function automatic logic ref_split(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) + nbytes(f3)) > 4;
    endfunction

    task automatic set_word(input int unsigned idx, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = AW'(idx); bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
        for (int b = 0; b < 4; b++) rb[17'(idx * 4 + b)] = d[8*b +: 8];
    endtask

    // Present a request from posedge+1 and hold it until stall clears.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic flt, output int stalls);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        stalls = 0;
        @(negedge clk);
        while (stall === 1'b1 && stalls < 4) begin
            stalls++;
            @(negedge clk);
        end
        rd  = rdata;
        flt = fault;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, w, a, wd;
        logic        flt, we, ef, es;
        logic [2:0]  f3;
        int          st;
        logic [2:0]  legal_f3 [5];
        logic [2:0]  bad_f3 [3];
        logic        flt_we [3];
        logic [2:0]  flt_f3 [3];
        logic [31:0] flt_a  [3];

        legal_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bad_f3   = '{3'b011, 3'b110, 3'b111};
        flt_we   = '{1'b1, 1'b0, 1'b1};
        flt_f3   = '{3'b010, 3'b011, 3'b100};
        flt_a    = '{32'h0002_0000, 32'h0000_0000, 32'h0000_0000};
        n_cmp = 0; n_err = 0; cnt_exp = 0;
        bd_we = 1'b0; bd_addr = '0; bd_data = 32'h0;
        init_mem = 1'b1;
        rst = 1'b1;
        present(1'b0, 3'b010, 32'h2, 32'h0);
        for (int i = 0; i < NWORDS; i++) begin
            w = pat(i);
            for (int b = 0; b < 4; b++) rb[4*i + b] = w[8*b +: 8];
        end

        // Outputs held at zero while reset is asserted, even with a request.
        #3;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_cnt", 32'(misalign_cnt), 32'h0);
        check("op_read", 32'(mem_op_read), 32'h2);
        @(posedge clk); #1;
        init_mem = 1'b0;
        req_valid = 1'b0;
        rst = 1'b0;
        set_word(0, 32'h4433_2211);
        set_word(1, 32'h8877_6655);
        set_word(NWORDS - 1, 32'hAABB_CCDD);

        // Loads from the plan.
        access(1'b0, 3'b010, 32'h2, 32'h0, rd, flt, st);
        check("lw2_stall", 32'(st), 32'h1);
        check("lw2_rdata", rd, 32'h6655_4433);
        check("lw2_cnt", 32'(misalign_cnt), 32'h1);
        access(1'b0, 3'b101, 32'h1, 32'h0, rd, flt, st);
        check("lhu1_stall", 32'(st), 32'h0);
        check("lhu1_rdata", rd, 32'h0000_3322);
        access(1'b0, 3'b001, 32'h3, 32'h0, rd, flt, st);
        check("lh3_stall", 32'(st), 32'h1);
        check("lh3_rdata", rd, 32'h0000_5544);
        access(1'b0, 3'b000, 32'h7, 32'h0, rd, flt, st);
        check("lb7_rdata", rd, 32'hFFFF_FF88);
        check("cnt_after_loads", 32'(misalign_cnt), 32'h2);

        // Split across the top word wraps to word 0.
        present(1'b0, 3'b010, 32'h0001_FFFE, 32'h0);
        @(negedge clk);
        check("wrap_c0_stall", 32'(stall), 32'h1);
        check("wrap_c0_addr", 32'(mem_addr), 32'h7FFF);
        @(negedge clk);
        check("wrap_c1_addr", 32'(mem_addr), 32'h0);
        check("wrap_c1_stall", 32'(stall), 32'h0);
        check("wrap_c1_rdata", rdata, 32'h2211_AABB);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Misaligned store, both memory cycles observed.
        present(1'b1, 3'b010, 32'h1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_c0_addr", 32'(mem_addr), 32'h0);
        check("sw_c0_be", 32'(mem_be), 32'hE);
        check("sw_c0_wdata", mem_wdata, 32'hADBE_EF00);
        check("sw_c0_we", 32'(mem_we), 32'h1);
        check("sw_c0_stall", 32'(stall), 32'h1);
        @(negedge clk);
        check("sw_c1_addr", 32'(mem_addr), 32'h1);
        check("sw_c1_be", 32'(mem_be), 32'h1);
        check("sw_c1_wdata", mem_wdata, 32'h0000_00DE);
        check("sw_c1_we", 32'(mem_we), 32'h1);
        check("sw_c1_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        ref_store(3'b010, 32'h1, 32'hDEAD_BEEF);
        access(1'b0, 3'b010, 32'h0, 32'h0, rd, flt, st);
        check("sw_rb_w0", rd, 32'hADBE_EF11);
        access(1'b0, 3'b010, 32'h4, 32'h0, rd, flt, st);
        check("sw_rb_w1", rd, 32'h8877_66DE);
        check("cnt_after_sw", 32'(misalign_cnt), 32'h4);

        // Faulting requests: no write, no stall, counter untouched.
        for (int k = 0; k < 3; k++) begin
            present(flt_we[k], flt_f3[k], flt_a[k], 32'hCAFE_F00D);
            @(negedge clk);
            check("flt_fault", 32'(fault), 32'h1);
            check("flt_mem_we", 32'(mem_we), 32'h0);
            check("flt_stall", 32'(stall), 32'h0);
            check("flt_rdata", rdata, 32'h0);
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("flt_cnt", 32'(misalign_cnt), 32'h4);
        end
        access(1'b0, 3'b010, 32'h0, 32'h0, rd, flt, st);
        check("flt_nowrite_w0", rd, 32'hADBE_EF11);

        // Request dropped during the second cycle suppresses the upper write.
        present(1'b1, 3'b010, 32'h1, 32'h1122_3344);
        @(negedge clk);
        check("drop_c0_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("drop_c1_we", 32'(mem_we), 32'h0);
        check("drop_c1_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rb[1] = 8'h44; rb[2] = 8'h33; rb[3] = 8'h22;
        access(1'b0, 3'b010, 32'h0, 32'h0, rd, flt, st);
        check("drop_w0", rd, 32'h2233_4411);
        access(1'b0, 3'b010, 32'h4, 32'h0, rd, flt, st);
        check("drop_w1", rd, 32'h8877_66DE);
        check("drop_cnt", 32'(misalign_cnt), 32'h5);

        // Reset asserted in the second cycle of a split store.
        set_word(0, 32'h4433_2211);
        set_word(1, 32'h8877_6655);
        present(1'b1, 3'b010, 32'h1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("rs_c0_stall", 32'(stall), 32'h1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rs_stall", 32'(stall), 32'h0);
        check("rs_mem_we", 32'(mem_we), 32'h0);
        check("rs_mem_be", 32'(mem_be), 32'h0);
        check("rs_mem_addr", 32'(mem_addr), 32'h0);
        check("rs_mem_wdata", mem_wdata, 32'h0);
        check("rs_rdata", rdata, 32'h0);
        check("rs_fault", 32'(fault), 32'h0);
        check("rs_cnt", 32'(misalign_cnt), 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        check("rs_mem0", mem[0], 32'hADBE_EF11);
        check("rs_mem1", mem[1], 32'h8877_6655);
        rb[1] = 8'hEF; rb[2] = 8'hBE; rb[3] = 8'hAD;
        access(1'b0, 3'b010, 32'h0, 32'h0, rd, flt, st);
        check("rs_idle_stall", 32'(st), 32'h0);
        check("rs_idle_rdata", rd, 32'hADBE_EF11);
        cnt_exp = 0;

        // Random traffic against the byte-level reference model.
        for (int n = 0; n < 400; n++) begin
            int unsigned sel, reg_sel;
            we  = 1'(($urandom_range(0, 1)));
            sel = $urandom_range(0, 15);
            f3  = (sel < 14) ? legal_f3[sel % 5] : bad_f3[$urandom_range(0, 2)];
            reg_sel = $urandom_range(0, 9);
            if (reg_sel < 6)      a = 32'($urandom_range(0, 31));
            else if (reg_sel < 9) a = 32'h0001_FFE0 + 32'($urandom_range(0, 31));
            else                  a = 32'h0002_0000 + 32'($urandom_range(0, 65535));
            wd = $urandom;
            ef = ref_fault(we, f3, a);
            es = !ef && ref_split(f3, a);
            access(we, f3, a, wd, rd, flt, st);
            check("rnd_fault", 32'(flt), 32'(ef));
            check("rnd_stalls", 32'(st), 32'(es));
            if (!ef && !we) check("rnd_rdata", rd, ref_load(f3, a));
            if (!ef && we) ref_store(f3, a, wd);
            if (es) cnt_exp++;
            check("rnd_cnt", 32'(misalign_cnt), 32'(cnt_exp));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
